gpr_file_mp: RTL and testbench

//   Parametrised general-purpose register file, successor to the fixed 32x32 two-read GPR bank.

---
 rtl/gpr_file_mp.sv | 112 +++++++++++
 tb/tb_gpr_file_mp.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gpr_file_mp.sv
// Multi-port GPR file with byte-enabled writes, write-to-read bypass
// and a hardware clear sequencer started by rst or clr_req.
module gpr_file_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_W/8-1:0]   wr_be,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr_req,
    output logic                  busy,
    output logic                  wr_drop
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   merged;
    logic                wr_zero;
    logic                wr_ok;

    assign wr_zero = (ZERO_REG != 0) && (wr_addr == '0);
    assign wr_ok   = wr_en && !rst && !busy && (state == S_IDLE)
                   && !clr_req && !wr_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
            busy    <= 1'b1;
            wr_drop <= 1'b0;
        end else begin
            wr_drop <= wr_en && (busy || (state == S_IDLE && clr_req));
            unique case (state)
                S_IDLE: begin
                    if (clr_req) begin
                        state   <= S_CLEAR;
                        clr_cnt <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (clr_cnt == '1) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

    // Storage has no reset; the clear sweep defines every entry.
    always_ff @(posedge clk) begin
        if (!rst && state == S_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_comb begin
        merged = mem[wr_addr];
        for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) merged[8*i +: 8] = wr_data[8*i +: 8];
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rq;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rq = mem[ra];
            if ((ZERO_REG != 0) && ra == '0) begin
                rq = '0;
            end else if (busy || rst) begin
                rq = '0;
            end else if ((BYPASS != 0) && wr_ok && wr_addr == ra) begin
                rq = merged;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rq;
    end

endmodule

// File: tb/tb_gpr_file_mp.sv
// Directed bench for gpr_file_mp: a bypass/zero-reg build and a
// plain build (no bypass, ordinary entry 0) driven side by side.
module tb_gpr_file_mp;

    logic         clk = 1'b0;
    logic         rst;
    logic [19:0]  rd_addr;
    logic [127:0] rd_a;
    logic [127:0] rd_b;
    logic         wr_en;
    logic [4:0]   wr_addr;
    logic [3:0]   wr_be;
    logic [31:0]  wr_data;
    logic         clr_req;
    logic         busy_a, busy_b;
    logic         drop_a, drop_b;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    gpr_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy_a), .wr_drop(drop_a)
    );

    gpr_file_mp #(
        .DATA_W(32), .ADDR_W(5), .NRD(4), .ZERO_REG(0), .BYPASS(0)
    ) dut_plain (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be),
        .wr_data(wr_data), .clr_req(clr_req),
        .busy(busy_b), .wr_drop(drop_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [3:0] be,
                      input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_be   = be;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic rd_all(input logic [4:0] a);
        rd_addr = {a, a, a, a};
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_be   = '0;
        wr_data = '0;
        clr_req = 1'b0;

        step();
        check("rst_busy", {31'd0, busy_a}, 32'd1);
        check("rst_drop", {31'd0, drop_a}, 32'd0);
        rd_addr = {5'd4, 5'd3, 5'd2, 5'd1};
        #1;
        check("rst_rd0", rd_a[31:0], 32'd0);
        step();

        // sweep, with a write attempted in its first cycle
        rst     = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_be   = 4'hF;
        wr_data = 32'h1234_5678;
        step();
        n = 1;
        check("sweep_drop", {31'd0, drop_a}, 32'd1);
        wr_en = 1'b0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check("sweep_len", n, 32'd32);
        check("sweep_busy_plain", {31'd0, busy_b}, 32'd0);
        check("sweep_drop_clr", {31'd0, drop_a}, 32'd0);
        for (int a = 0; a < 32; a++) begin
            rd_all(a[4:0]);
            check($sformatf("swept%0d", a), rd_b[31:0], 32'd0);
        end

        // byte-enabled write
        wr(5'd5, 4'hF, 32'h1122_3344);
        wr(5'd5, 4'b0101, 32'hAABB_CCDD);
        check("be_drop", {31'd0, drop_a}, 32'd0);
        rd_all(5'd5);
        check("be_merge", rd_a[31:0], 32'h11BB_33DD);
        check("be_merge_p3", rd_a[127:96], 32'h11BB_33DD);

        // bypass vs. plain
        wr(5'd7, 4'hF, 32'h0102_0304);
        rd_addr = {5'd0, 5'd0, 5'd7, 5'd0};
        wr_en   = 1'b1;
        wr_addr = 5'd7;
        wr_be   = 4'hF;
        wr_data = 32'hDEAD_BEEF;
        #1;
        check("byp_new", rd_a[63:32], 32'hDEAD_BEEF);
        check("byp_old", rd_b[63:32], 32'h0102_0304);
        step();
        wr_en = 1'b0;
        #1;
        check("byp_plain_next", rd_b[63:32], 32'hDEAD_BEEF);

        // zero register
        rd_all(5'd0);
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_be   = 4'hF;
        wr_data = 32'hFFFF_FFFF;
        #1;
        check("zero_byp", rd_a[31:0], 32'd0);
        step();
        wr_en = 1'b0;
        #1;
        check("zero_drop", {31'd0, drop_a}, 32'd0);
        check("zero_p0", rd_a[31:0], 32'd0);
        check("zero_p1", rd_a[63:32], 32'd0);
        check("zero_p2", rd_a[95:64], 32'd0);
        check("zero_p3", rd_a[127:96], 32'd0);
        check("zero_plain", rd_b[31:0], 32'hFFFF_FFFF);

        // four ports, distinct entries
        wr(5'd1, 4'hF, 32'hA1A1_A1A1);
        wr(5'd2, 4'hF, 32'hB2B2_B2B2);
        wr(5'd31, 4'hF, 32'hC3C3_C3C3);
        rd_addr = {5'd31, 5'd1, 5'd2, 5'd1};
        #1;
        check("p0_a1", rd_a[31:0], 32'hA1A1_A1A1);
        check("p1_a2", rd_a[63:32], 32'hB2B2_B2B2);
        check("p2_a1", rd_a[95:64], 32'hA1A1_A1A1);
        check("p3_a31", rd_a[127:96], 32'hC3C3_C3C3);

        // empty byte mask is a silent no-op
        wr(5'd2, 4'h0, 32'h0000_0000);
        check("be0_drop", {31'd0, drop_a}, 32'd0);
        check("be0_keep", rd_a[63:32], 32'hB2B2_B2B2);

        // clr_req with a simultaneous write
        clr_req = 1'b1;
        wr(5'd3, 4'hF, 32'h5555_5555);
        clr_req = 1'b0;
        check("clr_busy", {31'd0, busy_a}, 32'd1);
        check("clr_drop", {31'd0, drop_a}, 32'd1);
        rd_addr = {5'd31, 5'd1, 5'd2, 5'd1};
        #1;
        check("clr_rd_zero", rd_a[127:96], 32'd0);

        // reset once clr_cnt reaches 10
        for (int i = 0; i < 10; i++) step();
        check("mid_busy", {31'd0, busy_a}, 32'd1);
        rst = 1'b1;
        step();
        check("mid_rst_drop", {31'd0, drop_a}, 32'd0);
        rst = 1'b0;
        n = 0;
        while (busy_a && n < 100) begin
            step();
            n++;
        end
        check("rst_mid_len", n, 32'd32);
        rd_all(5'd31);
        check("post_clr_31", rd_a[31:0], 32'd0);
        rd_all(5'd3);
        check("post_clr_3", rd_b[31:0], 32'd0);
        rd_all(5'd1);
        check("post_clr_1", rd_b[31:0], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
